// File: rtl/uninasoc_pkg.sv
// Shared SoC constants: AXI widths and response codes, timer register offsets and CTRL layout.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package uninasoc_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [11:0] TIMER_CTRL_OFF    = 12'h000;
    localparam logic [11:0] TIMER_COUNT_OFF   = 12'h004;
    localparam logic [11:0] TIMER_COMPARE_OFF = 12'h008;
    localparam logic [11:0] TIMER_STATUS_OFF  = 12'h00C;

    // CTRL fields; packed MSB-first so presc sits above the single-bit flags
    typedef struct packed {
        logic [7:0] presc;
        logic       auto_reload;
        logic       irq_en;
        logic       en;
    } timer_ctrl_t;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Software view of CTRL: EN[0], IRQ_EN[1], AUTO_RELOAD[2], PRESC[15:8], rest zero
    function automatic logic [31:0] ctrl_to_word(input timer_ctrl_t c);
        return {16'h0000, c.presc, 5'b00000, c.auto_reload, c.irq_en, c.en};
    endfunction

    // Byte-lane merge of a write into an existing 32-bit register value
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_timer_core.sv
// Timer datapath: optional prescaler, 32-bit counter, compare match and sticky MATCH flag.
// Latency: register writes and ticks take effect at the next clock edge; irq follows MATCH combinationally.
// Backpressure: none; write strobes from the bus side are always accepted. Macro AXIL_TIMER_PRESCALER_EN enables PRESC.
module axil_timer_core
    import uninasoc_pkg::*;
#(
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ctrl_we,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic        status_we,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output timer_ctrl_t ctrl,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        match,
    output logic        irq
);

    logic        tick;
    logic [31:0] nxt;
    logic        hit;

`ifdef AXIL_TIMER_PRESCALER_EN
    logic [7:0] psc_cnt;

    assign tick = ctrl.en && (psc_cnt == ctrl.presc);

    // Prescale counter: restarts when disabled or when CTRL is rewritten, wraps after PRESC+1 cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_cnt <= 8'h00;
        end else if (!ctrl.en || ctrl_we || tick) begin
            psc_cnt <= 8'h00;
        end else begin
            psc_cnt <= psc_cnt + 8'd1;
        end
    end
`else
    assign tick = ctrl.en;
`endif

    // A software COUNT write overrides the tick and suppresses the compare for that cycle
    assign nxt = count + 32'd1;
    assign hit = tick && !count_we && (nxt == compare);
    assign irq = match && ctrl.irq_en;

    // CTRL register; PRESC is only writable when the prescaler is built in
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            if (wr_strb[0]) begin
                ctrl.en          <= wr_data[0];
                ctrl.irq_en      <= wr_data[1];
                ctrl.auto_reload <= wr_data[2];
            end
`ifdef AXIL_TIMER_PRESCALER_EN
            if (wr_strb[1]) begin
                ctrl.presc <= wr_data[15:8];
            end
`endif
        end
    end

    // Counter: software write wins, otherwise advance on tick with optional reload at match
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= 32'h0;
        end else if (count_we) begin
            count <= apply_strb(count, wr_data, wr_strb);
        end else if (tick) begin
            count <= (hit && ctrl.auto_reload) ? 32'h0 : nxt;
        end
    end

    // Compare value; the new value is used for matching from the following cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            compare <= RESET_COMPARE;
        end else if (compare_we) begin
            compare <= apply_strb(compare, wr_data, wr_strb);
        end
    end

    // Sticky MATCH flag: a new match beats a simultaneous write-1-to-clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (status_we && wr_strb[0] && wr_data[0]) begin
            match <= 1'b0;
        end
    end

endmodule

// File: rtl/axil_timer.sv
// AXI4-Lite slave wrapper for the timer: address decode, write/read channel FSMs, register readback.
// Latency: AW+W accepted in the cycle both are valid, B valid next cycle; AR accepted at once, R valid next cycle.
// Backpressure: one outstanding write and one outstanding read; held B/R stall new requests. Macro AXIL_TIMER_PRESCALER_EN.
module axil_timer
    import uninasoc_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = uninasoc_pkg::AXI_ADDR_WIDTH,
    parameter int          AXI_DATA_WIDTH = uninasoc_pkg::AXI_DATA_WIDTH,
    parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      irq_o
);

    if (AXI_DATA_WIDTH != 32) begin : g_data_width_check
        $error("axil_timer: AXI_DATA_WIDTH must be 32");
    end

    wr_state_t   w_state, w_next;
    rd_state_t   r_state, r_next;
    logic        wr_fire, rd_fire;
    logic [11:0] w_off;
    logic        w_ctrl, w_count, w_cmp, w_stat, w_mapped;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    timer_ctrl_t ctrl;
    logic [31:0] count, compare;
    logic        match;

    // Only the low 12 address bits select a register
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:12], s_axi_araddr[AXI_ADDR_WIDTH-1:12]};

    // Full 12-bit compare also rejects unaligned offsets, since all registers are word aligned
    assign w_off    = s_axi_awaddr[11:0];
    assign w_ctrl   = (w_off == TIMER_CTRL_OFF);
    assign w_count  = (w_off == TIMER_COUNT_OFF);
    assign w_cmp    = (w_off == TIMER_COMPARE_OFF);
    assign w_stat   = (w_off == TIMER_STATUS_OFF);
    assign w_mapped = w_ctrl || w_count || w_cmp || w_stat;

    axil_timer_core #(
        .RESET_COMPARE (RESET_COMPARE)
    ) u_core (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ctrl_we    (wr_fire && w_ctrl),
        .count_we   (wr_fire && w_count),
        .compare_we (wr_fire && w_cmp),
        .status_we  (wr_fire && w_stat),
        .wr_data    (s_axi_wdata[31:0]),
        .wr_strb    (s_axi_wstrb),
        .ctrl       (ctrl),
        .count      (count),
        .compare    (compare),
        .match      (match),
        .irq        (irq_o)
    );

    // Channel state registers; reset drops any pending response immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write channel: take address and data together, then hold B until the master takes it
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        wr_fire       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    s_axi_awready = 1'b1;
                    s_axi_wready  = 1'b1;
                    wr_fire       = 1'b1;
                    w_next        = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Read channel: accept AR when idle, then hold R until the master takes it
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        rd_fire       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    s_axi_arready = 1'b1;
                    rd_fire       = 1'b1;
                    r_next        = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Readback mux; unmapped or unaligned offsets return zero with SLVERR
    always_comb begin
        rd_val  = 32'h0;
        rd_resp = AXI_RESP_OKAY;
        case (s_axi_araddr[11:0])
            TIMER_CTRL_OFF:    rd_val = ctrl_to_word(ctrl);
            TIMER_COUNT_OFF:   rd_val = count;
            TIMER_COMPARE_OFF: rd_val = compare;
            TIMER_STATUS_OFF:  rd_val = {31'h0, match};
            default:           rd_resp = AXI_RESP_SLVERR;
        endcase
    end

    // Response registers, captured at the handshake and held stable while valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bresp_q <= AXI_RESP_OKAY;
            rresp_q <= AXI_RESP_OKAY;
            rdata_q <= 32'h0;
        end else begin
            if (wr_fire) begin
                bresp_q <= w_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            if (rd_fire) begin
                rresp_q <= rd_resp;
                rdata_q <= rd_val;
            end
        end
    end

    assign s_axi_bresp = bresp_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rdata = rdata_q;

endmodule
